demux_1x3x32: RTL and testbench

DEMUX_1X3X32 -- requirements
Module: demux_1x3x32

---
 rtl/demux_1x3x32.sv | 172 +++++++++++++++++
 tb/tb_demux_1x3x32.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x3x32.sv
// demux_1x3x32: routes packets from one input stream to one of three
// registered output destinations.
//
// The destination select S is sampled on the accepted start-of-packet word.
// Subsequent words follow that destination until end-of-packet. Packets
// addressed to S=3 are discarded and counted. Words that arrive in IDLE
// without a start-of-packet marker are orphans; they are discarded and
// counted as well. The drop counter saturates.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   D, D_valid, D_sop, D_eop input word and framing
//   S                        destination select (0..2 route, 3 drop)
//   D_ready                  input accepted when D_valid & D_ready
//   Q0, Q1, Q2               per-destination output word registers
//   Q_valid, Q_eop           per-destination valid / last-of-packet flags
//   Q_ready                  per-destination take strobe
//   drop_cnt                 saturating count of dropped packets/orphans
//   busy                     high while a packet is in progress
//
// Optional feature (macro DEMUX_WORD_CNT_EN): adds cnt0..cnt2, 16-bit
// wrapping counts of words delivered on each destination.

module demux_1x3x32 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  D,
  input  logic              D_valid,
  input  logic              D_sop,
  input  logic              D_eop,
  input  logic [1:0]        S,
  output logic              D_ready,
  output logic [WIDTH-1:0]  Q0,
  output logic [WIDTH-1:0]  Q1,
  output logic [WIDTH-1:0]  Q2,
  output logic [2:0]        Q_valid,
  output logic [2:0]        Q_eop,
  input  logic [2:0]        Q_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
`ifdef DEMUX_WORD_CNT_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   q_q [3];
  logic [2:0]         qv_q;
  logic [2:0]         qe_q;
  logic [DROP_W-1:0]  drop_q;

  logic               routed;
  logic [1:0]         tgt;
  logic [3:0]         avail;
  logic               accept;
  logic [2:0]         load;
  logic               drop_evt;

  // A word is routed when it starts a packet to a real destination, or
  // continues a packet in PASS. Only routed words can be back-pressured;
  // the padded top bit of avail keeps the index in range for any tgt.
  always_comb begin
    routed = 1'b0;
    tgt    = sel_q;
    if (state_q == PASS) begin
      routed = 1'b1;
    end else if (state_q == IDLE && D_sop && S != 2'd3) begin
      routed = 1'b1;
      tgt    = S;
    end
    avail   = {1'b1, ~qv_q | Q_ready};
    D_ready = routed ? avail[tgt] : 1'b1;
  end

  assign accept   = D_valid & D_ready;
  assign drop_evt = accept & (state_q == IDLE) & ~routed;

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (accept && routed && tgt == 2'(i)) load[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (D_sop) begin
            if (S != 2'd3) begin
              sel_d = S;
              if (!D_eop) state_d = PASS;
            end else if (!D_eop) begin
              state_d = DROP;
            end
          end
        end
        PASS, DROP: begin
          if (D_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      qv_q    <= '0;
      qe_q    <= '0;
      drop_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      // A load in the same cycle as a delivery keeps the slot valid.
      for (int unsigned i = 0; i < 3; i++) begin
        if (load[i]) begin
          q_q[i]  <= D;
          qe_q[i] <= D_eop;
          qv_q[i] <= 1'b1;
        end else if (Q_ready[i]) begin
          qv_q[i] <= 1'b0;
        end
      end
      if (drop_evt && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign Q0       = q_q[0];
  assign Q1       = q_q[1];
  assign Q2       = q_q[2];
  assign Q_valid  = qv_q;
  assign Q_eop    = qe_q;
  assign drop_cnt = drop_q;
  assign busy     = (state_q != IDLE);

`ifdef DEMUX_WORD_CNT_EN
  logic [15:0] cnt_q [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (qv_q[i] && Q_ready[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_demux_1x3x32.sv
// Testbench for demux_1x3x32: scoreboard of expected words per destination,
// pushed when a word is accepted and popped when the destination takes it.
`timescale 1ns/1ps
module tb_demux_1x3x32;
  localparam int W  = 32;
  localparam int DW = 8;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  D = '0;
  logic          D_valid = 1'b0;
  logic          D_sop = 1'b0;
  logic          D_eop = 1'b0;
  logic [1:0]    S = '0;
  logic          D_ready;
  logic [W-1:0]  Q0, Q1, Q2;
  logic [2:0]    Q_valid, Q_eop;
  logic [2:0]    Q_ready = 3'b111;
  logic [DW-1:0] drop_cnt;
  logic          busy;
`ifdef DEMUX_WORD_CNT_EN
  logic [15:0]   cnt0, cnt1, cnt2;
`endif

  always #5 clk = ~clk;

  demux_1x3x32 #(.WIDTH(W), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .D(D), .D_valid(D_valid), .D_sop(D_sop), .D_eop(D_eop), .S(S),
    .D_ready(D_ready),
    .Q0(Q0), .Q1(Q1), .Q2(Q2),
    .Q_valid(Q_valid), .Q_eop(Q_eop), .Q_ready(Q_ready),
    .drop_cnt(drop_cnt), .busy(busy)
`ifdef DEMUX_WORD_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef enum int {M_IDLE, M_PASS, M_DROP} mstate_t;
  typedef struct packed {
    logic         eop;
    logic [W-1:0] d;
  } ent_t;

  mstate_t     m_state = M_IDLE;
  logic [1:0]  m_sel = '0;
  int          m_drop = 0;
  int unsigned m_cnt [3];
  ent_t        sb [3][$];
  ent_t        last [3];
  int          stall2 = 0;
  bit          rand_ready = 1'b0;
  logic [2:0]  base_ready = 3'b111;

  function automatic logic [W-1:0] qword(input int n);
    case (n)
      0:       return Q0;
      1:       return Q1;
      default: return Q2;
    endcase
  endfunction

  task automatic model_clear();
    m_state = M_IDLE;
    m_sel   = '0;
    m_drop  = 0;
    for (int n = 0; n < 3; n++) begin
      sb[n].delete();
      last[n] = '0;
      m_cnt[n] = 0;
    end
  endtask

  // One clock: compare outputs at the negedge, update the model at the posedge.
  task automatic tick(output bit acc);
    bit         routed;
    logic [1:0] t;
    bit         mready;
    logic [2:0] dl;
    ent_t       e;
    ent_t       exp_e;
    if (rand_ready) Q_ready = 3'($urandom);
    else            Q_ready = base_ready;
    if (stall2 > 0) begin
      Q_ready[2] = 1'b0;
      stall2--;
    end
    @(negedge clk);
    routed = 1'b0;
    t = m_sel;
    if (m_state == M_PASS) routed = 1'b1;
    else if (m_state == M_IDLE && D_sop && S != 2'd3) begin
      routed = 1'b1;
      t = S;
    end
    mready = routed ? (sb[t].size() == 0 || Q_ready[t]) : 1'b1;
    check_eq("D_ready", 64'(D_ready), 64'(mready));
    check_eq("busy", 64'(busy), 64'(m_state != M_IDLE));
    check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    for (int n = 0; n < 3; n++) begin
      exp_e = (sb[n].size() != 0) ? sb[n][0] : last[n];
      check_eq($sformatf("Q_valid[%0d]", n), 64'(Q_valid[n]), 64'(sb[n].size() != 0));
      check_eq($sformatf("Q%0d", n), 64'(qword(n)), 64'(exp_e.d));
      check_eq($sformatf("Q_eop[%0d]", n), 64'(Q_eop[n]), 64'(exp_e.eop));
      dl[n] = (sb[n].size() != 0) && Q_ready[n];
    end
`ifdef DEMUX_WORD_CNT_EN
    check_eq("cnt0", 64'(cnt0), 64'(m_cnt[0]));
    check_eq("cnt1", 64'(cnt1), 64'(m_cnt[1]));
    check_eq("cnt2", 64'(cnt2), 64'(m_cnt[2]));
`endif
    acc = D_valid && mready;
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      if (dl[n]) begin
        void'(sb[n].pop_front());
        m_cnt[n] = (m_cnt[n] + 1) & 32'hFFFF;
      end
    end
    if (acc) begin
      e.eop = D_eop;
      e.d   = D;
      case (m_state)
        M_IDLE: begin
          if (routed) begin
            sb[t].push_back(e);
            last[t] = e;
            m_sel = t;
            if (!D_eop) m_state = M_PASS;
          end else begin
            if (m_drop < DROP_MAX) m_drop++;
            if (D_sop && !D_eop) m_state = M_DROP;
          end
        end
        M_PASS: begin
          sb[m_sel].push_back(e);
          last[m_sel] = e;
          if (D_eop) m_state = M_IDLE;
        end
        default: if (D_eop) m_state = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    D_valid = 1'b0;
    D_sop   = 1'b0;
    D_eop   = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit sop, input bit eop, input logic [1:0] s);
    bit acc;
    int budget;
    D = d; D_valid = 1'b1; D_sop = sop; D_eop = eop; S = s;
    acc = 1'b0;
    budget = 0;
    while (!acc) begin
      tick(acc);
      budget++;
      if (!acc && budget > 200) begin
        check_eq("send_accept", 64'(acc), 64'(1));
        break;
      end
    end
    D_valid = 1'b0;
    D_sop   = 1'b0;
    D_eop   = 1'b0;
  endtask

  // S only matters on the first word; later words carry random S.
  task automatic send_pkt(input logic [1:0] sel, input int len, input bit with_sop);
    for (int i = 0; i < len; i++)
      send_word($urandom, with_sop && i == 0, i == len - 1, (i == 0) ? sel : 2'($urandom));
  endtask

  task automatic do_reset();
    D_valid = 1'b0; D_sop = 1'b0; D_eop = 1'b0;
    rst_n = 1'b0;
    #2;
    check_eq("rst Q0", 64'(Q0), 64'(0));
    check_eq("rst Q1", 64'(Q1), 64'(0));
    check_eq("rst Q2", 64'(Q2), 64'(0));
    check_eq("rst Q_valid", 64'(Q_valid), 64'(0));
    check_eq("rst Q_eop", 64'(Q_eop), 64'(0));
    check_eq("rst drop_cnt", 64'(drop_cnt), 64'(0));
    check_eq("rst busy", 64'(busy), 64'(0));
`ifdef DEMUX_WORD_CNT_EN
    check_eq("rst cnt0", 64'(cnt0), 64'(0));
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w [5];
    bit acc;
    model_clear();
    #1;
    do_reset();
    idle(2);

    // 3-word packet to destination 1, all ready
    base_ready = 3'b111;
    send_pkt(2'd1, 3, 1'b1);
    idle(3);
    check_eq("pkt1 busy", 64'(busy), 64'(0));

    // Destination 2 stalled at start of packet, then released
    stall2 = 4;
    send_pkt(2'd2, 4, 1'b1);
    idle(3);

    // Dropped packet followed by an orphan word
    do_reset();
    send_pkt(2'd3, 4, 1'b1);
    send_pkt(2'd0, 1, 1'b0);
    idle(2);
    check_eq("drop+orphan cnt", 64'(drop_cnt), 64'(2));
    check_eq("drop+orphan busy", 64'(busy), 64'(0));
    check_eq("drop+orphan Q_valid", 64'(Q_valid), 64'(0));

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) send_pkt(2'd3, 1, 1'b1);
    idle(1);
    check_eq("drop sat", 64'(drop_cnt), 64'(DROP_MAX));

    // Reset in the middle of a packet to destination 0
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    base_ready = 3'b110;
    send_word(w[0], 1'b1, 1'b0, 2'd0);
    D = w[1]; D_valid = 1'b1; D_sop = 1'b0; D_eop = 1'b0; S = 2'd0;
    tick(acc);
    check_eq("mid stall acc", 64'(acc), 64'(0));
    check_eq("mid Q_valid0", 64'(Q_valid[0]), 64'(1));
    do_reset();
    base_ready = 3'b111;
    for (int i = 1; i < 5; i++) send_word(w[i], 1'b0, i == 4, 2'($urandom));
    idle(2);
    check_eq("mid orphans", 64'(drop_cnt), 64'(4));
    check_eq("mid Q_valid", 64'(Q_valid), 64'(0));

    // Random traffic with random per-destination back-pressure
    do_reset();
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      send_pkt(2'($urandom), $urandom_range(1, 5), ($urandom % 8) != 0);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    base_ready = 3'b111;
    idle(4);
    check_eq("rand flush Q_valid", 64'(Q_valid), 64'(0));

`ifdef DEMUX_WORD_CNT_EN
    do_reset();
    send_pkt(2'd0, 65537, 1'b1);
    idle(2);
    check_eq("wc cnt0", 64'(cnt0), 64'(1));
    check_eq("wc cnt1", 64'(cnt1), 64'(0));
    check_eq("wc cnt2", 64'(cnt2), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
